pc_gen: RTL and testbench

Parametrised fetch-stage program-counter generator with trap/redirect steering and an optional direct-mapped branch target buffer (BTB). It holds the fetch PC, selects the next PC each cycle (trap, EX redirect, stall hold, BTB-predicted target, or sequential PC+4) and trains the BTB from resolved branches reported by EX. Sits at the head of the 5-stage pipeline; PC feeds the instruction memory and the IF/ID register.

---
 rtl/pc_pkg.sv | 29 ++
 rtl/pc_gen_if.sv | 34 +++
 rtl/pc_btb.sv | 76 +++++++
 rtl/pc_gen.sv | 100 ++++++++++
 tb/tb_pc_gen.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: next-PC select codes,
// 2-bit branch counter encodings and the sequential PC increment.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_TRAP     = 3'd0,
        SEL_REDIRECT = 3'd1,
        SEL_HOLD     = 3'd2,
        SEL_PRED     = 3'd3,
        SEL_SEQ      = 3'd4
    } next_sel_e;

    localparam logic [1:0] CNT_SNT  = 2'b00;
    localparam logic [1:0] CNT_WNT  = 2'b01;
    localparam logic [1:0] CNT_WT   = 2'b10;
    localparam logic [1:0] CNT_ST   = 2'b11;
    localparam logic [1:0] CNT_INIT = 2'b10;

    localparam int unsigned PC_INC = 4;

    // Saturating step of a 2-bit direction counter toward the resolved outcome.
    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Bus between the hazard unit / EX stage (master) and the fetch PC generator (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    // Handshake: every *_VALID is a valid-only qualifier with no ready; the PC
    // generator samples it on each rising CLK edge and never back-pressures, and
    // the fields it qualifies are don't-care while it is low.
    logic            STALLF;
    logic            TRAP_VALID;
    logic [XLEN-1:0] TRAP_VEC;
    logic            REDIRECT_VALID;
    logic [XLEN-1:0] REDIRECT_PC;
    logic            UPD_VALID;
    logic [XLEN-1:0] UPD_PC;
    logic [XLEN-1:0] UPD_TARGET;
    logic            UPD_TAKEN;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PC_PLUS4;
    logic            PRED_TAKEN;
    logic [XLEN-1:0] PRED_TARGET;

    modport master (
        output STALLF, TRAP_VALID, TRAP_VEC, REDIRECT_VALID, REDIRECT_PC,
        output UPD_VALID, UPD_PC, UPD_TARGET, UPD_TAKEN,
        input  PC, PC_PLUS4, PRED_TAKEN, PRED_TARGET
    );

    modport slave (
        input  STALLF, TRAP_VALID, TRAP_VEC, REDIRECT_VALID, REDIRECT_PC,
        input  UPD_VALID, UPD_PC, UPD_TARGET, UPD_TAKEN,
        output PC, PC_PLUS4, PRED_TAKEN, PRED_TARGET
    );

endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// training from resolved branches with 2-bit saturating direction counters.
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_taken_i
);

    localparam int IDX  = $clog2(DEPTH);
    localparam int TAGW = XLEN - IDX - 2;

    logic [DEPTH-1:0] valid_q;
    logic [TAGW-1:0]  tag_q [DEPTH];
    logic [XLEN-1:0]  tgt_q [DEPTH];
    logic [1:0]       cnt_q [DEPTH];

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDX-1:0]  upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;
    logic            upd_alloc;
    logic            unused_low_bits;

    assign lk_idx  = lookup_pc_i[IDX+1:2];
    assign lk_tag  = lookup_pc_i[XLEN-1:IDX+2];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign pred_taken_o  = lk_hit && cnt_q[lk_idx][1];
    assign pred_target_o = tgt_q[lk_idx];

    assign upd_idx   = upd_pc_i[IDX+1:2];
    assign upd_tag   = upd_pc_i[XLEN-1:IDX+2];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_alloc = upd_valid_i && !upd_hit && upd_taken_i;

    // Instructions are word aligned, so the byte offset never selects an entry.
    assign unused_low_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Only the valid bits are reset; stale tags/targets are masked by valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q <= '0;
        end else if (upd_alloc) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (upd_valid_i) begin
            if (upd_hit) begin
                cnt_q[upd_idx] <= cnt_step(cnt_q[upd_idx], upd_taken_i);
                if (upd_taken_i) begin
                    tgt_q[upd_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                tag_q[upd_idx] <= upd_tag;
                tgt_q[upd_idx] <= upd_target_i;
                cnt_q[upd_idx] <= CNT_INIT;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with trap/redirect/stall steering and next-PC select.
// Defining the BTB_EN macro adds the pc_btb predictor; otherwise PC is purely sequential.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_DEPTH    = 16
) (
    input  logic    CLK,
    input  logic    RST,
    pc_gen_if.slave pc_bus
);

    if (XLEN < 8) begin : g_bad_xlen
        $error("pc_gen: XLEN must be at least 8");
    end
    if (BTB_DEPTH < 2 || BTB_DEPTH > 256 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_gen: BTB_DEPTH must be a power of two in 2..256");
    end
    if (XLEN < $clog2(BTB_DEPTH) + 3) begin : g_bad_tag
        $error("pc_gen: XLEN too small to hold a BTB tag");
    end
    if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_vector
        $error("pc_gen: RESET_VECTOR must be word aligned");
    end

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_raw;
    logic [XLEN-1:0] pc_plus4;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    next_sel_e       sel;

    assign pc_plus4 = pc_q + XLEN'(PC_INC);

`ifdef BTB_EN
    pc_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .CLK           (CLK),
        .RST           (RST),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_valid_i   (pc_bus.UPD_VALID),
        .upd_pc_i      (pc_bus.UPD_PC),
        .upd_target_i  (pc_bus.UPD_TARGET),
        .upd_taken_i   (pc_bus.UPD_TAKEN)
    );
`else
    logic unused_upd;

    assign pred_taken  = 1'b0;
    assign pred_target = '0;
    assign unused_upd  = ^{pc_bus.UPD_VALID, pc_bus.UPD_PC, pc_bus.UPD_TARGET, pc_bus.UPD_TAKEN};
`endif

    // Trap and redirect sit above the stall: a flush must land even while IF is held.
    always_comb begin
        sel = SEL_SEQ;
        if (pc_bus.TRAP_VALID) begin
            sel = SEL_TRAP;
        end else if (pc_bus.REDIRECT_VALID) begin
            sel = SEL_REDIRECT;
        end else if (pc_bus.STALLF) begin
            sel = SEL_HOLD;
        end else if (pred_taken) begin
            sel = SEL_PRED;
        end
    end

    always_comb begin
        pc_raw = pc_plus4;
        case (sel)
            SEL_TRAP:     pc_raw = pc_bus.TRAP_VEC;
            SEL_REDIRECT: pc_raw = pc_bus.REDIRECT_PC;
            SEL_HOLD:     pc_raw = pc_q;
            SEL_PRED:     pc_raw = pred_target;
            default:      pc_raw = pc_plus4;
        endcase
        pc_d = {pc_raw[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_bus.PC          = pc_q;
    assign pc_bus.PC_PLUS4    = pc_plus4;
    assign pc_bus.PRED_TAKEN  = pred_taken;
    assign pc_bus.PRED_TARGET = pred_target;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed table, hand-written BTB/wrap/reset sequences and random
// traffic, all checked against a word-level next-PC and BTB model.
module tb_pc_gen;

    localparam int          XLEN  = 32;
    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int          DEPTH = 16;
`ifdef BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic        trap;
        logic [31:0] tvec;
        logic        redir;
        logic [31:0] rpc;
        logic        upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utaken;
    } stim_t;

    typedef struct {
        string       nm;
        stim_t       s;
        logic [31:0] exp_pc;
        logic        exp_pred;
    } vec_t;

    logic CLK;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_cnt   [DEPTH];

    vec_t tbl [8];

    pc_gen_if #(.XLEN(XLEN)) bus ();

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .BTB_DEPTH    (DEPTH)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .pc_bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a / (32'd4 * DEPTH);
    endfunction

    function automatic bit m_pred(input logic [31:0] a);
        int i;
        i = m_idx(a);
        return BTB_ON && m_valid[i] && (m_tag[i] == m_tagof(a)) && (m_cnt[i] >= 2);
    endfunction

    function automatic logic [31:0] model_next(input stim_t s);
        logic [31:0] n;
        if (s.trap)               n = s.tvec;
        else if (s.redir)         n = s.rpc;
        else if (s.stall)         n = m_pc;
        else if (m_pred(m_pc))    n = m_tgt[m_idx(m_pc)];
        else                      n = m_pc + 32'd4;
        return n & ~32'h3;
    endfunction

    task automatic model_train(input stim_t s);
        int i;
        if (!BTB_ON || !s.upd) return;
        i = m_idx(s.upc);
        if (m_valid[i] && m_tag[i] == m_tagof(s.upc)) begin
            if (s.utaken) begin
                if (m_cnt[i] < 3) m_cnt[i] = m_cnt[i] + 1;
                m_tgt[i] = s.utgt;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
        end else if (s.utaken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tagof(s.upc);
            m_tgt[i]   = s.utgt;
            m_cnt[i]   = 2;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        exp_q.delete();
        exp_q.push_back(RV);
    endtask

    // ---------------- driver tasks ----------------
    function automatic stim_t mk(input logic stall, input logic trap, input logic [31:0] tvec,
                                 input logic redir, input logic [31:0] rpc);
        stim_t s;
        s.stall = stall;  s.trap = trap;   s.tvec = tvec;
        s.redir = redir;  s.rpc  = rpc;
        s.upd   = 1'b0;   s.upc  = '0;     s.utgt = '0;   s.utaken = 1'b0;
        return s;
    endfunction

    function automatic stim_t mku(input logic [31:0] upc, input logic [31:0] utgt, input logic taken,
                                  input logic redir, input logic [31:0] rpc);
        stim_t s;
        s = mk(1'b0, 1'b0, '0, redir, rpc);
        s.upd = 1'b1;  s.upc = upc;  s.utgt = utgt;  s.utaken = taken;
        return s;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] hi;
        case ($urandom_range(0, 2))
            0:       hi = 32'h0000_0000;
            1:       hi = 32'h0000_0040;
            default: hi = 32'h0000_1000;
        endcase
        return hi + 32'($urandom_range(0, 7)) * 32'd4 +
               (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.stall  = ($urandom_range(0, 99) < 20);
        s.trap   = ($urandom_range(0, 99) < 4);
        s.tvec   = $urandom();
        s.redir  = ($urandom_range(0, 99) < 15);
        s.rpc    = pick_addr();
        s.upd    = ($urandom_range(0, 99) < 40);
        s.upc    = pick_addr();
        s.utgt   = pick_addr();
        s.utaken = ($urandom_range(0, 99) < 65);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.STALLF         = s.stall;
        bus.TRAP_VALID     = s.trap;
        bus.TRAP_VEC       = s.tvec;
        bus.REDIRECT_VALID = s.redir;
        bus.REDIRECT_PC    = s.rpc;
        bus.UPD_VALID      = s.upd;
        bus.UPD_PC         = s.upc;
        bus.UPD_TARGET     = s.utgt;
        bus.UPD_TAKEN      = s.utaken;
    endtask

    // ---------------- scoreboard ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_now(input string nm);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_queue: got 0 entries want 1", nm);
            return;
        end
        e    = exp_q.pop_front();
        m_pc = e;
        cmp({nm, "_pc"}, bus.PC, e);
        cmp({nm, "_plus4"}, bus.PC_PLUS4, e + 32'd4);
        cmp({nm, "_pred"}, 32'(bus.PRED_TAKEN), 32'(m_pred(e)));
        if (m_pred(e) || !BTB_ON)
            cmp({nm, "_tgt"}, bus.PRED_TARGET, BTB_ON ? m_tgt[m_idx(e)] : 32'd0);
    endtask

    // Inputs change on the falling edge; the DUT is checked on the next falling edge.
    task automatic step(input string nm, input stim_t s);
        apply(s);
        exp_q.push_back(model_next(s));
        model_train(s);
        @(negedge CLK);
        check_now(nm);
    endtask

    // ---------------- test ----------------
    initial begin
        stim_t idle;
        idle = mk(1'b0, 1'b0, '0, 1'b0, '0);

        tbl[0] = '{"seq1",            mk(0, 0, 32'h0,  0, 32'h0),   32'h104, 1'b0};
        tbl[1] = '{"seq2",            mk(0, 0, 32'h0,  0, 32'h0),   32'h108, 1'b0};
        tbl[2] = '{"stall",           mk(1, 0, 32'h0,  0, 32'h0),   32'h108, 1'b0};
        tbl[3] = '{"stall_redir",     mk(1, 0, 32'h0,  1, 32'h200), 32'h200, 1'b0};
        tbl[4] = '{"trap_over_redir", mk(0, 1, 32'h80, 1, 32'h300), 32'h080, 1'b0};
        tbl[5] = '{"trap_align",      mk(1, 1, 32'h7F, 0, 32'h0),   32'h07C, 1'b0};
        tbl[6] = '{"redir_align",     mk(0, 0, 32'h0,  1, 32'h202), 32'h200, 1'b0};
        tbl[7] = '{"seq3",            mk(0, 0, 32'h0,  0, 32'h0),   32'h204, 1'b0};

        RST = 1'b0;
        apply(idle);
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        check_now("reset");

        // directed table from the reset vector
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].nm, tbl[i].s);
            cmp({tbl[i].nm, "_tbl_pc"}, bus.PC, tbl[i].exp_pc);
            cmp({tbl[i].nm, "_tbl_pred"}, 32'(bus.PRED_TAKEN), 32'(tbl[i].exp_pred));
        end

        // PC+4 wrap at the top of the address space
        step("wrap_load", mk(0, 0, 32'h0, 1, 32'hFFFF_FFFC));
        cmp("wrap_plus4", bus.PC_PLUS4, 32'h0);
        step("wrap", idle);
        cmp("wrap_pc", bus.PC, 32'h0);

        // train, predict, weaken
        step("train40", mku(32'h40, 32'h400, 1'b1, 1'b0, '0));
        step("fetch40", mk(0, 0, '0, 1, 32'h40));
        cmp("fetch40_pred", 32'(bus.PRED_TAKEN), 32'(BTB_ON));
        cmp("fetch40_tgt", bus.PRED_TARGET, BTB_ON ? 32'h400 : 32'h0);
        step("follow40", idle);
        cmp("follow40_pc", bus.PC, BTB_ON ? 32'h400 : 32'h44);
        step("nt1", mku(32'h40, 32'h0, 1'b0, 1'b0, '0));
        step("nt2", mku(32'h40, 32'h0, 1'b0, 1'b0, '0));
        step("refetch40", mk(0, 0, '0, 1, 32'h40));
        cmp("refetch40_pred", 32'(bus.PRED_TAKEN), 32'd0);

        // same-edge update and lookup of one entry uses the old counter
        step("weak40", mku(32'h40, 32'h400, 1'b1, 1'b1, 32'h40));
        step("same_cycle", mku(32'h40, 32'h400, 1'b1, 1'b0, '0));
        cmp("same_cycle_pc", bus.PC, 32'h44);
        step("strong40", mk(0, 0, '0, 1, 32'h40));
        cmp("strong40_pred", 32'(bus.PRED_TAKEN), 32'(BTB_ON));

        // aliasing: 0x80 shares the index of 0x40 and evicts it
        step("alloc80", mku(32'h80, 32'h800, 1'b1, 1'b0, '0));
        step("alias40", mk(0, 0, '0, 1, 32'h40));
        cmp("alias40_pred", 32'(bus.PRED_TAKEN), 32'd0);
        step("alias80", mk(0, 0, '0, 1, 32'h80));
        cmp("alias80_pred", 32'(bus.PRED_TAKEN), 32'(BTB_ON));
        step("follow80", idle);
        cmp("follow80_pc", bus.PC, BTB_ON ? 32'h800 : 32'h84);

        // asynchronous reset pulse between clock edges, ignored redirect while held
        step("pre_rst", mk(0, 0, '0, 1, 32'h80));
        #2 RST = 1'b0;
        #1;
        cmp("async_rst_pc", bus.PC, RV);
        cmp("async_rst_pred", 32'(bus.PRED_TAKEN), 32'd0);
        apply(mk(0, 0, '0, 1, 32'h500));
        @(negedge CLK);
        cmp("held_rst_pc", bus.PC, RV);
        apply(idle);
        RST = 1'b1;
        model_reset();
        check_now("rst_release");
        step("post_rst_stall", mk(1, 0, '0, 0, '0));
        cmp("post_rst_stall_pc", bus.PC, RV);
        step("post_rst_80", mk(0, 0, '0, 1, 32'h80));
        cmp("post_rst_80_pred", 32'(bus.PRED_TAKEN), 32'd0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step("rand", rand_stim());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
